// File: rtl/panel_dsel_ctrl.sv
// panel_dsel_ctrl: front-panel display-select controller.
// Conditions the raw STEP and MODE pushbuttons (2-flop sync + debounce + rising-edge pulse)
// and either steps the one-hot display select manually or auto-scans it every SCAN_PERIOD
// cycles. Auto-scan holds while a panel switch operation is active.
//
// Optional feature macro: PANEL_HALT_SNAP_EN
//   When defined, a falling edge on the synchronized run signal snaps the selection to AC
//   and returns to manual mode. When undefined, run is ignored.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   btn_step   raw STEP pushbutton (asynchronous, active-high)
//   btn_mode   raw MODE pushbutton (asynchronous, active-high)
//   sw_active  panel switch operation in progress; freezes auto-scan
//   run        processor running (used only with PANEL_HALT_SNAP_EN)
//   dsel       one-hot display select: bit5=state .. bit0=IO bus
//   sel_idx    binary selection index: 0=state .. 5=IO bus
//   scan_mode  1=AUTO, 0=MANUAL
module panel_dsel_ctrl #(
  parameter int unsigned DB_CYCLES   = 50000,
  parameter int unsigned SCAN_PERIOD = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_step,
  input  logic       btn_mode,
  input  logic       sw_active,
  input  logic       run,
  output logic [5:0] dsel,
  output logic [2:0] sel_idx,
  output logic       scan_mode
);

  localparam int unsigned DbW   = $clog2(DB_CYCLES);
  localparam int unsigned ScanW = $clog2(SCAN_PERIOD);

  localparam logic [DbW-1:0]   DbMax   = DbW'(DB_CYCLES - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_PERIOD - 1);

  localparam logic [0:0] StManual = 1'b0;
  localparam logic [0:0] StAuto   = 1'b1;

  // Button conditioning; index 0 = STEP, index 1 = MODE.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, level_q, prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [1:0]     pulse;
  logic           step_pulse, mode_pulse;

  assign btn_raw = {btn_mode, btn_step};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      prev_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= level_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          level_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced rising edge only; releases produce nothing.
  assign pulse      = level_q & ~prev_q;
  assign step_pulse = pulse[0];
  assign mode_pulse = pulse[1];

  // Halt snap
  logic halt_snap;

`ifdef PANEL_HALT_SNAP_EN
  logic run_s1_q, run_s2_q, run_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      run_s1_q   <= run;
      run_s2_q   <= run_s1_q;
      run_prev_q <= run_s2_q;
    end
  end

  assign halt_snap = run_prev_q & ~run_s2_q;
`else
  logic unused_run;
  assign unused_run = run;
  assign halt_snap  = 1'b0;
`endif

  // Selection state machine
  logic [0:0]       mode_q, mode_d;
  logic [2:0]       sel_q, sel_d, sel_next;
  logic [5:0]       dsel_q, dsel_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;

  assign sel_next = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;

  always_comb begin
    mode_d     = mode_q;
    sel_d      = sel_q;
    scan_cnt_d = scan_cnt_q;
    if (halt_snap) begin
      mode_d     = StManual;
      sel_d      = 3'd2;
      scan_cnt_d = '0;
    end else if (mode_q == StManual) begin
      // Mode wins over a coincident step; the step is dropped.
      if (mode_pulse) begin
        mode_d     = StAuto;
        scan_cnt_d = '0;
      end else if (step_pulse) begin
        sel_d = sel_next;
      end
    end else begin
      // Any button leaves AUTO and suppresses a coincident scan expiry.
      if (mode_pulse || step_pulse) begin
        mode_d = StManual;
      end else if (!sw_active) begin
        if (scan_cnt_q == ScanMax) begin
          sel_d      = sel_next;
          scan_cnt_d = '0;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
    end
  end

  assign dsel_d = 6'b100000 >> sel_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= StManual;
      sel_q      <= 3'd0;
      dsel_q     <= 6'b100000;
      scan_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      dsel_q     <= dsel_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign dsel      = dsel_q;
  assign sel_idx   = sel_q;
  assign scan_mode = mode_q;

endmodule

// File: doc/panel_dsel_ctrl.md
Name: panel_dsel_ctrl

Overview:
Front-panel display-select controller. Drives the 6-bit one-hot dsel vector that chooses which register group the front-panel display mux shows: state, status, AC, MB, MQ or IO bus. It conditions two raw panel pushbuttons (STEP, MODE) and either steps through the selections manually or auto-scans them at a fixed period. Auto-scan freezes while a panel switch operation is active.

Parameters:
DB_CYCLES, 50000, debounce stability window in clk cycles; minimum 2.
SCAN_PERIOD, 50000000, clk cycles per auto-scan step; minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_step  input  1  raw STEP pushbutton, asynchronous to clk, active-high
btn_mode  input  1  raw MODE pushbutton, asynchronous to clk, active-high
sw_active  input  1  panel switch operation in progress; freezes auto-scan
run  input  1  processor running, from the run-LED decode; used only with the optional feature
dsel  output  6  one-hot display select; bit5=state, 4=status, 3=AC, 2=MB, 1=MQ, 0=IO bus
sel_idx  output  3  binary index of the selection: 0=state … 5=IO bus
scan_mode  output  1  1=AUTO, 0=MANUAL

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset clears all state regardless of debounce or scan progress:
  - dsel=6'b100000, sel_idx=0, scan_mode=0.
  - All synchronizers, debounced levels, previous-level registers and counters go to 0.
- Input conditioning, per button, independent:
  - 2-flop synchronizer; output s.
  - Debounce counter: if s equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 with s still different, the debounced level takes s and the counter clears.
  - A press pulse is the debounced rising edge (level & ~previous level); it lasts exactly 1 cycle. Releases generate nothing.
- Latency: a raw press first sampled at edge 1 and held stable updates dsel/sel_idx/scan_mode at edge DB_CYCLES+3. A glitch shorter than DB_CYCLES cycles generates no pulse.
- Selection advance: sel_idx 0→1→…→5→0 (wrap). dsel = 6'b100000 >> sel_idx and is always exactly one-hot.
- State machine (scan_mode):
  - MANUAL:
    - step pulse → advance.
    - mode pulse → go to AUTO and clear the scan counter; no advance.
  - AUTO:
    - Scan counter increments each cycle while sw_active=0 and holds while sw_active=1.
    - At SCAN_PERIOD-1 the selection advances and the counter clears.
    - mode pulse → MANUAL, selection held.
    - step pulse → MANUAL, selection held, no advance.
- Simultaneous events:
  - mode and step pulses in the same cycle: the mode pulse wins and the step pulse is discarded.
  - A scan expiry coinciding with a mode or step pulse in AUTO: no advance; the mode change applies.
- sw_active has no effect in MANUAL.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
PANEL_HALT_SNAP_EN
- Defined:
  - run passes through a 2-flop synchronizer.
  - On its falling edge (processor halted), sel_idx=2 (AC), dsel=6'b001000, scan_mode=0 and the scan counter clears.
  - This has priority over button pulses and scan expiry in the same cycle.
- Undefined: run is unused, and halting has no effect on the selection.

Test Plan:
(All tests use DB_CYCLES=4, SCAN_PERIOD=8.)
1. Reset: assert reset mid-debounce and mid-scan → dsel=6'b100000, sel_idx=0 and scan_mode=0 asynchronously; deasserting reset alone generates no pulse.
2. Debounce: btn_step high for 3 cycles then low → no change. btn_step held high → dsel goes 100000→010000 at the 7th edge after first sample. Holding the button longer gives no further advance.
3. Wrap: six clean step presses in MANUAL → sel_idx 1,2,3,4,5,0; dsel returns to 100000.
4. Auto-scan: mode press → scan_mode=1; sel_idx advances every 8 cycles. Hold sw_active=1 for 20 cycles → no advance and the counter is preserved; it resumes on release.
5. Priority: mode and step pressed together (same cycle pulses) in MANUAL → scan_mode=1, sel_idx unchanged. Step press in AUTO → scan_mode=0, sel_idx unchanged.
6. PANEL_HALT_SNAP_EN: AUTO at sel_idx=4, run 1→0 → two sync edges later dsel=001000, sel_idx=2, scan_mode=0. With the macro undefined → no change.
